pc_sequencer: RTL and testbench

Next-PC controller for the single-cycle core; the block that drives and sequences the word-addressed program-counter register. Each cycle it selects among sequential increment, relative branch, absolute jump, trap vector, stall hold and halt, and registers the result as the fetch address. Sits between decode/control (request inputs) and instruction memory (`pc` output). An optional return-address stack supports call/return.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_ras.sv | 57 +++++
 rtl/pc_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state codes, default
// reset/trap vectors and the next-PC source select encoding.
// Latency: n/a (package). Backpressure: n/a.
package pc_pkg;

  // Encodings are visible on the state port: BOOT=0, RUN=1, HALT=2.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_DEFAULT  = 32'h0000_0010;

  // Source of the next fetch address.
  typedef enum logic [2:0] {
    SEL_TRAP   = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_RET    = 3'd3,
    SEL_BRANCH = 3'd4,
    SEL_INC    = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
// Latency: push/pop take effect at the next clock edge; top is combinational from state.
// Backpressure: none; the caller must not pop when empty (pop is ignored if it does).
//
// Ports: clk, rst_n (sync, active low), push + push_data, pop,
//        top (most recent entry), full, empty.
module pc_ras
  #(
    parameter int W     = 32,
    parameter int DEPTH = 4
  )
  (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
  );

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr_q;   // next slot to write; ptr_q-1 is the top entry
  logic [PW:0]   cnt_q;   // live entries, saturates at DEPTH

  assign top   = mem[ptr_q - PW'(1)];
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  // Storage is not reset: an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      // When full, ptr_q already points at the oldest entry, so the write
      // overwrites it and the count stays saturated.
      ptr_q <= ptr_q + PW'(1);
      if (!full) begin
        cnt_q <= cnt_q + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PW'(1);
      cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: BOOT/RUN/HALT FSM, next-PC mux and the registered fetch address.
// Latency: one cycle from a request sampled at an edge to the new pc after that edge.
// Backpressure: stall holds pc; halt/resume is the only handshake, no other flow control.
//
// Ports: clk, rst_n (sync, active low); requests stall, branch_taken/branch_off,
//        jump/jump_target, call, ret, trap, halt, resume; outputs pc, pc_valid,
//        state (BOOT=0 RUN=1 HALT=2), ras_overflow, ras_underflow (1-cycle pulses).
// Build option: define PC_RETURN_STACK_EN to instantiate the return stack; without
// it call acts as jump, ret as a sequential step, and the RAS flags are tied to 0.
module pc_sequencer
  import pc_pkg::*;
  #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(PC_RESET_DEFAULT),
    parameter logic [PC_W-1:0] TRAP_PC   = PC_W'(PC_TRAP_DEFAULT),
    parameter int              RAS_DEPTH = 4
  )
  (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_off,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic [1:0]      state,
    output logic            ras_overflow,
    output logic            ras_underflow
  );

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
  end

  pc_state_e       state_q, state_d;
  pc_sel_e         sel;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            pc_valid_q;
  logic            boot_armed_q;  // set once one post-reset edge has been spent in BOOT

`ifdef PC_RETURN_STACK_EN
  logic            push, pop;
  logic            ras_full, ras_empty;
  logic [PC_W-1:0] ras_top;
  logic            ovf_q, unf_q;

  pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pc_q + PC_W'(1)),
    .pop       (pop),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
`ifdef PC_RETURN_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        if (boot_armed_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (trap) begin
          sel = SEL_TRAP;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (stall) begin
          sel = SEL_HOLD;
        end else if (jump || call) begin
          sel  = SEL_JUMP;
`ifdef PC_RETURN_STACK_EN
          push = call;  // a simultaneous ret is dropped
`endif
        end else if (ret) begin
`ifdef PC_RETURN_STACK_EN
          pop = 1'b1;
          sel = ras_empty ? SEL_INC : SEL_RET;
`else
          sel = SEL_INC;
`endif
        end else if (branch_taken) begin
          sel = SEL_BRANCH;
        end else begin
          sel = SEL_INC;
        end
      end
      ST_HALT: begin
        if (trap) begin
          sel     = SEL_TRAP;
          state_d = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // All sums wrap modulo 2^PC_W.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_TRAP:   pc_d = TRAP_PC;
      SEL_JUMP:   pc_d = jump_target;
`ifdef PC_RETURN_STACK_EN
      SEL_RET:    pc_d = ras_top;
`endif
      SEL_BRANCH: pc_d = pc_q + branch_off;
      SEL_INC:    pc_d = pc_q + PC_W'(1);
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      boot_armed_q <= 1'b0;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
`ifdef PC_RETURN_STACK_EN
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      boot_armed_q <= 1'b1;
      pc_q         <= pc_d;
      pc_valid_q   <= (state_d == ST_RUN);
`ifdef PC_RETURN_STACK_EN
      ovf_q        <= push && ras_full;
      unf_q        <= pop && ras_empty;
`endif
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer: each record is one clock edge
// of requests plus the pc/pc_valid/state/flag values expected after that edge.
module tb_pc_sequencer;
  import pc_pkg::*;

`ifdef PC_RETURN_STACK_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  // Request bits of a vector.
  localparam logic [8:0] NONE = 9'h000;
  localparam logic [8:0] RST  = 9'h001;
  localparam logic [8:0] STL  = 9'h002;
  localparam logic [8:0] BR   = 9'h004;
  localparam logic [8:0] JMP  = 9'h008;
  localparam logic [8:0] CALL = 9'h010;
  localparam logic [8:0] RET  = 9'h020;
  localparam logic [8:0] TRP  = 9'h040;
  localparam logic [8:0] HLT  = 9'h080;
  localparam logic [8:0] RES  = 9'h100;

  localparam logic [1:0] B = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] H = 2'd2;

  typedef struct {
    logic [8:0]  req;
    logic [31:0] tgt;
    logic [31:0] off;
    logic [31:0] e_pc;
    logic        e_v;
    logic [1:0]  e_st;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic        clk;
  logic        rst_n, stall, branch_taken, jump, call, ret, trap, halt, resume;
  logic [31:0] branch_off, jump_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic [1:0]  state;
  logic        ras_overflow, ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t  vecs[$];
  string names[$];

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_off    (branch_off),
    .jump          (jump),
    .jump_target   (jump_target),
    .call          (call),
    .ret           (ret),
    .trap          (trap),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .state         (state),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [8:0] req, input logic [31:0] tgt,
                              input logic [31:0] off, input logic [31:0] e_pc,
                              input logic e_v, input logic [1:0] e_st,
                              input logic e_ovf, input logic e_unf);
    vec_t v;
    v.req = req; v.tgt = tgt; v.off = off; v.e_pc = e_pc;
    v.e_v = e_v; v.e_st = e_st; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  function automatic void add(input string nm, input vec_t v);
    names.push_back(nm);
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    rst_n        = ~v.req[0];
    stall        = v.req[1];
    branch_taken = v.req[2];
    jump         = v.req[3];
    call         = v.req[4];
    ret          = v.req[5];
    trap         = v.req[6];
    halt         = v.req[7];
    resume       = v.req[8];
    jump_target  = v.tgt;
    branch_off   = v.off;
    @(posedge clk);
    #1;
    check({nm, ".pc"},       pc,                    v.e_pc);
    check({nm, ".pc_valid"}, {31'b0, pc_valid},     {31'b0, v.e_v});
    check({nm, ".state"},    {30'b0, state},        {30'b0, v.e_st});
    check({nm, ".ovf"},      {31'b0, ras_overflow}, {31'b0, v.e_ovf});
    check({nm, ".unf"},      {31'b0, ras_underflow},{31'b0, v.e_unf});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0;
    ret = 1'b0; trap = 1'b0; halt = 1'b0; resume = 1'b0;
    branch_off = '0; jump_target = '0;

    // Reset and boot.
    add("rst0",     mk(RST,  0, 0, 32'h0, 0, B, 0, 0));
    add("rst1",     mk(RST,  0, 0, 32'h0, 0, B, 0, 0));
    add("rst2",     mk(RST,  0, 0, 32'h0, 0, B, 0, 0));
    add("boot",     mk(NONE, 0, 0, 32'h0, 0, B, 0, 0));
    add("run0",     mk(NONE, 0, 0, 32'h0, 1, R, 0, 0));
    add("inc1",     mk(NONE, 0, 0, 32'h1, 1, R, 0, 0));
    add("inc2",     mk(NONE, 0, 0, 32'h2, 1, R, 0, 0));
    add("inc3",     mk(NONE, 0, 0, 32'h3, 1, R, 0, 0));
    add("rst_mid",  mk(RST | JMP | TRP, 32'h40, 0, 32'h0, 0, B, 0, 0));
    add("boot2",    mk(JMP,  32'h40, 0, 32'h0, 0, B, 0, 0));
    add("run0b",    mk(NONE, 0, 0, 32'h0, 1, R, 0, 0));
    // Priority.
    add("jmp8",     mk(JMP, 32'h8, 0, 32'h8, 1, R, 0, 0));
    add("all_req",  mk(TRP | HLT | STL | JMP | BR, 32'h40, 32'h5, 32'h10, 1, R, 0, 0));
    add("jmp8b",    mk(JMP, 32'h8, 0, 32'h8, 1, R, 0, 0));
    add("stl_jmp",  mk(STL | JMP, 32'h40, 0, 32'h8, 1, R, 0, 0));
    add("jmp_br",   mk(JMP | BR, 32'h40, 32'h5, 32'h40, 1, R, 0, 0));
    // Branch and wrap.
    add("jmp20",    mk(JMP, 32'h20, 0, 32'h20, 1, R, 0, 0));
    add("br_m4",    mk(BR, 0, 32'hFFFF_FFFC, 32'h1C, 1, R, 0, 0));
    add("jmp_ff",   mk(JMP, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1, R, 0, 0));
    add("wrap",     mk(NONE, 0, 0, 32'h0, 1, R, 0, 0));
    add("jmp2",     mk(JMP, 32'h2, 0, 32'h2, 1, R, 0, 0));
    add("br_m3",    mk(BR, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, R, 0, 0));
    // Trap out of HALT.
    add("halt_a",   mk(HLT, 0, 0, 32'hFFFF_FFFF, 0, H, 0, 0));
    add("htrap",    mk(TRP | JMP, 32'h40, 0, 32'h10, 1, R, 0, 0));
    // Return stack (expectations follow the build option).
    add("jmp3",     mk(JMP, 32'h3, 0, 32'h3, 1, R, 0, 0));
    add("call1",    mk(CALL, 32'h100, 0, 32'h100, 1, R, 0, 0));
    add("ret1",     mk(RET, 0, 0, RAS_ON ? 32'h4 : 32'h101, 1, R, 0, 0));
    add("nest1",    mk(CALL, 32'h100, 0, 32'h100, 1, R, 0, 0));
    add("nest2",    mk(CALL, 32'h200, 0, 32'h200, 1, R, 0, 0));
    add("nest3",    mk(CALL, 32'h300, 0, 32'h300, 1, R, 0, 0));
    add("nest4",    mk(CALL, 32'h400, 0, 32'h400, 1, R, 0, 0));
    add("nest5",    mk(CALL, 32'h500, 0, 32'h500, 1, R, RAS_ON, 0));
    add("pop1",     mk(RET, 0, 0, RAS_ON ? 32'h401 : 32'h501, 1, R, 0, 0));
    add("pop2",     mk(RET, 0, 0, RAS_ON ? 32'h301 : 32'h502, 1, R, 0, 0));
    add("pop3",     mk(RET, 0, 0, RAS_ON ? 32'h201 : 32'h503, 1, R, 0, 0));
    add("pop4",     mk(RET, 0, 0, RAS_ON ? 32'h101 : 32'h504, 1, R, 0, 0));
    add("pop5",     mk(RET, 0, 0, RAS_ON ? 32'h102 : 32'h505, 1, R, 0, RAS_ON));
    add("call_ret", mk(CALL | RET, 32'h600, 0, 32'h600, 1, R, 0, 0));
    add("pop6",     mk(RET, 0, 0, RAS_ON ? 32'h103 : 32'h601, 1, R, 0, 0));
    add("pop7",     mk(RET, 0, 0, RAS_ON ? 32'h104 : 32'h602, 1, R, 0, RAS_ON));
    add("call7",    mk(CALL, 32'h700, 0, 32'h700, 1, R, 0, 0));
    add("stl_ret",  mk(STL | RET, 0, 0, 32'h700, 1, R, 0, 0));
    add("pop8",     mk(RET, 0, 0, RAS_ON ? 32'h105 : 32'h701, 1, R, 0, 0));
    add("seq_end",  mk(NONE, 0, 0, RAS_ON ? 32'h106 : 32'h702, 1, R, 0, 0));

    foreach (vecs[i]) apply(names[i], vecs[i]);

    // Halt/resume sequence: requests other than trap/resume are ignored in HALT.
    apply("h_jmp5",   mk(JMP, 32'h5, 0, 32'h5, 1, R, 0, 0));
    apply("h_halt",   mk(HLT, 0, 0, 32'h5, 0, H, 0, 0));
    apply("h_jmp",    mk(JMP | BR | CALL, 32'h40, 32'h7, 32'h5, 0, H, 0, 0));
    apply("h_idle",   mk(NONE, 0, 0, 32'h5, 0, H, 0, 0));
    apply("h_resume", mk(RES, 0, 0, 32'h5, 1, R, 0, 0));
    apply("h_inc",    mk(NONE, 0, 0, 32'h6, 1, R, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
